// File: rtl/byte_lane_ram_if.sv
// Bus bundle between the MCU and the byte-lane program/data RAM.
interface byte_lane_ram_if #(
  parameter int ADDR_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr;
  logic                  byt;
  logic [15:0]           wr_data;
  logic [15:0]           rd_data;

  modport master (output addr, output wr, output byt, output wr_data, input rd_data);
  modport slave  (input addr, input wr, input byt, input wr_data, output rd_data);
endinterface

// File: rtl/byte_lane_ram.sv
// Single-port 16-bit RAM split into two 8-bit lanes, byte-addressed, read-first,
// one-cycle registered read with little-endian zero-extended byte reads.
module byte_lane_ram #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic            clk,
    input  logic            rst,
    byte_lane_ram_if.slave  bus
);
    localparam int WW    = ADDR_WIDTH - 1;
    localparam int DEPTH = 2 ** WW;

    // Lane arrays keep their names so benches can preload them by hierarchy.
    logic [7:0] mem_hi [DEPTH];
    logic [7:0] mem_lo [DEPTH];

    logic [WW-1:0] widx;
    logic          we_hi, we_lo;
    logic [7:0]    wd_hi;
    logic [7:0]    hi_q, lo_q;
    logic          sel_q, byt_q, vld_q;
    logic [15:0]   rd_mux;

    assign widx  = bus.addr[ADDR_WIDTH-1:1];
    assign we_hi = rst & bus.wr & (~bus.byt | bus.addr[0]);
    assign we_lo = rst & bus.wr & (~bus.byt | ~bus.addr[0]);
    // A byte write to the odd address lands wr_data[7:0] in the high lane.
    assign wd_hi = bus.byt ? bus.wr_data[7:0] : bus.wr_data[15:8];

    // Data registers stay unreset so each lane maps onto a plain block RAM.
    always_ff @(posedge clk) begin
        if (we_hi) mem_hi[widx] <= wd_hi;
        hi_q <= mem_hi[widx];
    end

    always_ff @(posedge clk) begin
        if (we_lo) mem_lo[widx] <= bus.wr_data[7:0];
        lo_q <= mem_lo[widx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q <= 1'b0;
            byt_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            sel_q <= bus.addr[0];
            byt_q <= bus.byt;
            vld_q <= 1'b1;
        end
    end

    // vld_q forces zero from reset until the first post-reset read lands.
    always_comb begin
        rd_mux = 16'h0000;
        if (vld_q) begin
            if (byt_q) rd_mux = {8'h00, (sel_q ? hi_q : lo_q)};
            else       rd_mux = {hi_q, lo_q};
        end
    end

    assign bus.rd_data = rd_mux;
endmodule

// File: tb/tb_byte_lane_ram.sv
// Directed bench for byte_lane_ram with a byte-array reference model checked every cycle.
module tb_byte_lane_ram;
    localparam int AW    = 15;
    localparam int DEPTH = 2 ** (AW - 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    byte_lane_ram_if #(.ADDR_WIDTH(AW)) bus ();
    byte_lane_ram #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    // Reference: one byte per lane per word, plus a "has been written" flag.
    bit [7:0] mh [DEPTH];
    bit [7:0] ml [DEPTH];
    bit       kh [DEPTH];
    bit       kl [DEPTH];
    logic [15:0] exp_rd;
    bit          exp_ok = 1'b0;

    always @(posedge clk or negedge rst) begin
        int w;
        if (!rst) begin
            exp_rd <= 16'h0000;
            exp_ok <= 1'b1;
            mh[14'h2000] <= 8'h12; kh[14'h2000] <= 1'b1;
            ml[14'h2000] <= 8'h34; kl[14'h2000] <= 1'b1;
        end else begin
            w = int'(bus.addr[AW-1:1]);
            if (bus.byt) begin
                exp_ok <= bus.addr[0] ? kh[w] : kl[w];
                exp_rd <= {8'h00, (bus.addr[0] ? mh[w] : ml[w])};
            end else begin
                exp_ok <= kh[w] & kl[w];
                exp_rd <= {mh[w], ml[w]};
            end
            if (bus.wr) begin
                if (!bus.byt) begin
                    mh[w] <= bus.wr_data[15:8]; kh[w] <= 1'b1;
                    ml[w] <= bus.wr_data[7:0];  kl[w] <= 1'b1;
                end else if (bus.addr[0]) begin
                    mh[w] <= bus.wr_data[7:0];  kh[w] <= 1'b1;
                end else begin
                    ml[w] <= bus.wr_data[7:0];  kl[w] <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (exp_ok) begin
            n_cmp++;
            if (bus.rd_data !== exp_rd) begin
                n_err++;
                $display("FAIL model t=%0t rd_data got=%h want=%h", $time, bus.rd_data, exp_rd);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] want);
        n_cmp++;
        if (bus.rd_data !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", name, bus.rd_data, want);
        end
    endtask

    // Present one access and return #1 after the edge that captures it.
    task automatic acc(input logic [AW-1:0] a, input logic w, input logic b, input logic [15:0] d);
        bus.addr = a; bus.wr = w; bus.byt = b; bus.wr_data = d;
        @(posedge clk); #1;
        bus.wr = 1'b0;
    endtask

    initial begin
        bus.addr = '0; bus.wr = 1'b0; bus.byt = 1'b0; bus.wr_data = '0;
        dut.mem_hi[14'h2000] = 8'h12;
        dut.mem_lo[14'h2000] = 8'h34;
        repeat (3) @(posedge clk);
        #1 chk("reset_zero", 16'h0000);
        rst = 1'b1;

        acc(15'h4000, 1'b0, 1'b0, 16'h0);        chk("preload_word", 16'h1234);

        acc(15'h0100, 1'b1, 1'b0, 16'hBEEF);
        acc(15'h0100, 1'b0, 1'b1, 16'h0);        chk("byte_rd_lo", 16'h00EF);
        acc(15'h0101, 1'b0, 1'b1, 16'h0);        chk("byte_rd_hi", 16'h00BE);

        acc(15'h0100, 1'b1, 1'b0, 16'h1234);
        acc(15'h0101, 1'b1, 1'b1, 16'h77AA);
        acc(15'h0100, 1'b0, 1'b0, 16'h0);        chk("byte_wr_hi", 16'hAA34);
        acc(15'h0100, 1'b1, 1'b1, 16'h6655);
        acc(15'h0100, 1'b0, 1'b0, 16'h0);        chk("byte_wr_lo", 16'hAA55);

        acc(15'h0200, 1'b1, 1'b0, 16'h1111);
        acc(15'h0200, 1'b1, 1'b0, 16'h2222);     chk("read_first_old", 16'h1111);
        acc(15'h0200, 1'b0, 1'b0, 16'h0);        chk("read_first_new", 16'h2222);

        acc(15'h0201, 1'b0, 1'b0, 16'h0);        chk("odd_word_rd", 16'h2222);
        acc(15'h4000, 1'b0, 1'b0, 16'h0);        chk("stream_0", 16'h1234);
        acc(15'h0100, 1'b0, 1'b0, 16'h0);        chk("stream_1", 16'hAA55);
        acc(15'h0200, 1'b0, 1'b0, 16'h0);        chk("stream_2", 16'h2222);

        acc(15'h7FFE, 1'b1, 1'b0, 16'hC3A5);
        acc(15'h7FFF, 1'b0, 1'b1, 16'h0);        chk("top_word_byte", 16'h00C3);

        acc(15'h4000, 1'b0, 1'b0, 16'h0);
        #2 rst = 1'b0;
        #1 chk("async_reset", 16'h0000);
        acc(15'h0100, 1'b1, 1'b0, 16'h9999);
        chk("reset_hold", 16'h0000);
        #2 rst = 1'b1;
        acc(15'h0100, 1'b0, 1'b0, 16'h0);        chk("preserved_0100", 16'hAA55);
        acc(15'h4000, 1'b0, 1'b0, 16'h0);        chk("preserved_4000", 16'h1234);
        acc(15'h0201, 1'b0, 1'b1, 16'h0);        chk("preserved_hi", 16'h0022);

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
